// File: rtl/shift_edge_detector.sv
// shift_edge_detector
// Multi-channel delay line. Each channel has a registered edge detector on
// its input stage and a saturating counter of detected edges. Edge pulses are
// registered, so edge_pulse and edge_any are free of glitches.

module shift_edge_detector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [1:0]             edge_mode,
  input  logic                   cnt_clr,
  output logic [WIDTH-1:0]       data_out,
  output logic [WIDTH-1:0]       edge_pulse,
  output logic                   edge_any,
  output logic [WIDTH*CNT_W-1:0] edge_count
);

  localparam logic [1:0] MODE_NONE    = 2'b00;
  localparam logic [1:0] MODE_RISING  = 2'b01;
  localparam logic [1:0] MODE_FALLING = 2'b10;
  localparam logic [1:0] MODE_BOTH    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] edge_pulse_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic [DEPTH-1:0] stage_reg;
      logic             pulse_next;
      logic [CNT_W-1:0] count_reg;
      logic [CNT_W-1:0] count_next;

      // Delay line: stage 0 takes the input, higher stages take their
      // predecessor; everything holds while shifting is disabled.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          stage_reg <= '0;
        end else if (shift_en) begin
          stage_reg <= {stage_reg[DEPTH-2:0], data_in[gi]};
        end
      end

      // Edge qualification: the incoming bit is compared with the stage-0
      // value it is about to replace, so the pulse lines up with s[0]/s[1].
      always_comb begin
        pulse_next = 1'b0;
        if (shift_en) begin
          case (edge_mode)
            MODE_RISING:  pulse_next = data_in[gi] & ~stage_reg[0];
            MODE_FALLING: pulse_next = ~data_in[gi] & stage_reg[0];
            MODE_BOTH:    pulse_next = data_in[gi] ^ stage_reg[0];
            MODE_NONE:    pulse_next = 1'b0;
            default:      pulse_next = 1'b0;
          endcase
        end
      end

      // Registered one-cycle edge pulse.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          edge_pulse_reg[gi] <= 1'b0;
        end else begin
          edge_pulse_reg[gi] <= pulse_next;
        end
      end

      // Counter next state: clear wins over increment (a pulse in a clear
      // cycle is dropped), and the count sticks at all-ones.
      always_comb begin
        count_next = count_reg;
        if (cnt_clr) begin
          count_next = '0;
        end else if (edge_pulse_reg[gi] && (count_reg != CNT_MAX)) begin
          count_next = count_reg + 1'b1;
        end
      end

      // Counter state; runs independently of shift_en.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          count_reg <= '0;
        end else begin
          count_reg <= count_next;
        end
      end

      assign data_out[gi]                  = stage_reg[DEPTH-1];
      assign edge_count[gi*CNT_W +: CNT_W] = count_reg;
    end
  endgenerate

  assign edge_pulse = edge_pulse_reg;
  assign edge_any   = |edge_pulse_reg;

endmodule

// File: tb/tb_shift_edge_detector.sv
// Directed bench for shift_edge_detector. A main instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=3) share all inputs. Inputs change on the
// falling edge; outputs are checked on the falling edge after each rise.

module tb_shift_edge_detector;

  logic        clock;
  logic        reset;
  logic        shift_en;
  logic [3:0]  data_in;
  logic [1:0]  edge_mode;
  logic        cnt_clr;
  logic [3:0]  data_out;
  logic [3:0]  edge_pulse;
  logic        edge_any;
  logic [31:0] edge_count;
  logic [3:0]  s_data_out;
  logic [3:0]  s_edge_pulse;
  logic        s_edge_any;
  logic [11:0] s_edge_count;

  int n_cmp;
  int n_fail;

  shift_edge_detector #(.WIDTH(4), .DEPTH(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .shift_en(shift_en), .data_in(data_in),
    .edge_mode(edge_mode), .cnt_clr(cnt_clr), .data_out(data_out),
    .edge_pulse(edge_pulse), .edge_any(edge_any), .edge_count(edge_count)
  );

  shift_edge_detector #(.WIDTH(4), .DEPTH(4), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset), .shift_en(shift_en), .data_in(data_in),
    .edge_mode(edge_mode), .cnt_clr(cnt_clr), .data_out(s_data_out),
    .edge_pulse(s_edge_pulse), .edge_any(s_edge_any), .edge_count(s_edge_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] cnt(input int ch);
    return edge_count[ch*8 +: 8];
  endfunction

  function automatic logic [2:0] scnt(input int ch);
    return s_edge_count[ch*3 +: 3];
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_counts();
    shift_en = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; shift_en = 1'b0; data_in = '0; edge_mode = 2'b00; cnt_clr = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++;
    if ({data_out, edge_pulse, edge_any, edge_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: out=%b pulse=%b any=%b cnt=%h required all zero",
               data_out, edge_pulse, edge_any, edge_count);
    end
    $display("test_reset: data_out=%b edge_pulse=%b edge_count=%h", data_out, edge_pulse, edge_count);
    reset = 1'b0;
  endtask

  task automatic test_rising_latency();
    logic [3:0] exp_out;
    edge_mode = 2'b01;
    shift_en  = 1'b1;
    data_in   = 4'b0001;
    tick();
    n_cmp++;
    if (edge_pulse !== 4'b0001 || edge_any !== 1'b1 || cnt(0) !== 8'd0) begin
      n_fail++;
      $display("FAIL first_shift: pulse=%b any=%b cnt0=%0d required 0001/1/0",
               edge_pulse, edge_any, cnt(0));
    end
    data_in = 4'b0000;
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_out = (k == 4) ? 4'b0001 : 4'b0000;
      n_cmp++;
      if (data_out !== exp_out || edge_pulse !== 4'b0000 || edge_any !== 1'b0 || cnt(0) !== 8'd1) begin
        n_fail++;
        $display("FAIL latency_shift%0d: out=%b pulse=%b any=%b cnt0=%0d required %b/0000/0/1",
                 k, data_out, edge_pulse, edge_any, cnt(0), exp_out);
      end
      $display("test_rising_latency: shift %0d data_out=%b", k, data_out);
    end
    shift_en = 1'b0;
  endtask

  task automatic test_falling();
    logic [5:0] pat;
    logic       exp_p;
    pat = 6'b010011; // bit k = value at shift k+1: 1,1,0,0,1,0
    clear_counts();
    edge_mode = 2'b10;
    shift_en  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_in = {3'b000, pat[k]};
      tick();
      exp_p = (k == 2 || k == 5);
      n_cmp++;
      if (edge_pulse !== {3'b000, exp_p}) begin
        n_fail++;
        $display("FAIL falling_shift%0d: pulse=%b required %b", k + 1, edge_pulse, {3'b000, exp_p});
      end
      $display("test_falling: shift %0d in=%b pulse=%b", k + 1, pat[k], edge_pulse);
    end
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (cnt(0) !== 8'd2) begin
      n_fail++;
      $display("FAIL falling_count: cnt0=%0d required 2", cnt(0));
    end
  endtask

  task automatic test_both_and_none();
    logic v;
    clear_counts();
    edge_mode = 2'b11;
    shift_en  = 1'b1;
    v = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data_in = {2'b00, v, 1'b0};
      tick();
      n_cmp++;
      if (edge_pulse !== 4'b0010) begin
        n_fail++;
        $display("FAIL both_shift%0d: pulse=%b required 0010", k, edge_pulse);
      end
      v = ~v;
    end
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (cnt(1) !== 8'd10 || scnt(1) !== 3'd7) begin
      n_fail++;
      $display("FAIL both_count: cnt1=%0d sat_cnt1=%0d required 10/7", cnt(1), scnt(1));
    end
    $display("test_both: cnt1=%0d sat_cnt1=%0d", cnt(1), scnt(1));
    edge_mode = 2'b00;
    shift_en  = 1'b1;
    v = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      data_in = {2'b00, v, 1'b0};
      tick();
      n_cmp++;
      if (edge_pulse !== 4'b0000 || edge_any !== 1'b0) begin
        n_fail++;
        $display("FAIL none_shift%0d: pulse=%b any=%b required 0000/0", k, edge_pulse, edge_any);
      end
      v = ~v;
    end
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (cnt(1) !== 8'd10) begin
      n_fail++;
      $display("FAIL none_count: cnt1=%0d required 10", cnt(1));
    end
    $display("test_none: cnt1=%0d", cnt(1));
  endtask

  task automatic test_hold();
    logic [3:0] seq [4];
    logic [3:0] exp_p [4];
    seq[0] = 4'b1000; seq[1] = 4'b0000; seq[2] = 4'b0000; seq[3] = 4'b0100;
    exp_p[0] = 4'b1000; exp_p[1] = 4'b0000; exp_p[2] = 4'b0000; exp_p[3] = 4'b0100;
    clear_counts();
    edge_mode = 2'b01;
    shift_en  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = seq[k];
      tick();
      n_cmp++;
      if (edge_pulse !== exp_p[k]) begin
        n_fail++;
        $display("FAIL hold_load%0d: pulse=%b required %b", k + 1, edge_pulse, exp_p[k]);
      end
    end
    shift_en = 1'b0;
    data_in  = 4'b1111;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_cmp++;
      if (data_out !== 4'b1000 || edge_pulse !== 4'b0000 || cnt(2) !== 8'd1 || cnt(3) !== 8'd1) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: out=%b pulse=%b cnt2=%0d cnt3=%0d required 1000/0000/1/1",
                 k, data_out, edge_pulse, cnt(2), cnt(3));
      end
      $display("test_hold: idle %0d data_out=%b pulse=%b", k, data_out, edge_pulse);
    end
  endtask

  task automatic test_saturate_and_clear();
    logic v;
    clear_counts();
    edge_mode = 2'b11;
    shift_en  = 1'b1;
    v = 1'b0; // ch2 stage 0 currently holds 1
    for (int k = 1; k <= 9; k++) begin
      data_in = {1'b0, v, 2'b00};
      tick();
      v = ~v;
    end
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (scnt(2) !== 3'd7 || cnt(2) !== 8'd9) begin
      n_fail++;
      $display("FAIL saturate: sat_cnt2=%0d cnt2=%0d required 7/9", scnt(2), cnt(2));
    end
    $display("test_saturate: sat_cnt2=%0d cnt2=%0d", scnt(2), cnt(2));
    shift_en = 1'b1;
    data_in  = {1'b0, v, 2'b00};
    tick();
    n_cmp++;
    if (edge_pulse !== 4'b0100) begin
      n_fail++;
      $display("FAIL clr_setup: pulse=%b required 0100", edge_pulse);
    end
    shift_en = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_cmp++;
    if (cnt(2) !== 8'd0 || scnt(2) !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_priority: cnt2=%0d sat_cnt2=%0d required 0/0", cnt(2), scnt(2));
    end
    tick();
    n_cmp++;
    if (cnt(2) !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_lost_pulse: cnt2=%0d required 0", cnt(2));
    end
    $display("test_clear: cnt2=%0d", cnt(2));
  endtask

  task automatic test_async_reset();
    edge_mode = 2'b11;
    shift_en  = 1'b1;
    data_in   = 4'b1010;
    for (int k = 0; k < 4; k++) tick();
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (data_out !== 4'b1010 || cnt(3) !== 8'd1) begin
      n_fail++;
      $display("FAIL areset_setup: out=%b cnt3=%0d required 1010/1", data_out, cnt(3));
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({data_out, edge_pulse, edge_any, edge_count, s_edge_count} !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: out=%b pulse=%b any=%b cnt=%h required all zero",
               data_out, edge_pulse, edge_any, edge_count);
    end
    $display("test_async_reset: mid-cycle out=%b cnt=%h", data_out, edge_count);
    @(negedge clock);
    reset     = 1'b0;
    edge_mode = 2'b01;
    shift_en  = 1'b1;
    data_in   = 4'b1111;
    tick();
    n_cmp++;
    if (edge_pulse !== 4'b1111 || edge_any !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_shift: pulse=%b any=%b required 1111/1", edge_pulse, edge_any);
    end
    shift_en = 1'b0;
    tick();
    n_cmp++;
    if (cnt(0) !== 8'd1 || cnt(3) !== 8'd1 || edge_pulse !== 4'b0000) begin
      n_fail++;
      $display("FAIL post_reset_count: cnt0=%0d cnt3=%0d pulse=%b required 1/1/0000",
               cnt(0), cnt(3), edge_pulse);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_rising_latency();
    test_falling();
    test_both_and_none();
    test_hold();
    test_saturate_and_clear();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
